// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - Shared state encodings and constants for the UART receive controller
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    ERR_CHK = 3'd5
  } rx_state_e;

  // Smallest oversampling ratio that leaves room for a mid-bit sample.
  localparam int MIN_PRESCALE = 4;

  // Requested ratios below the minimum are run at the minimum.
  function automatic int clamp_prescale(input int presc);
    return (presc < MIN_PRESCALE) ? MIN_PRESCALE : presc;
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// rtl/uart_rx_edge_bit_cnt.sv - Oversample edge counter and frame bit counter with bit_end flag
module uart_rx_edge_bit_cnt #(
  parameter int PRESC_W   = 5,
  parameter int BIT_CNT_W = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 en,
  input  logic                 clr,
  input  logic [PRESC_W-1:0]   presc,
  output logic [PRESC_W-1:0]   edge_cnt,
  output logic [BIT_CNT_W-1:0] bit_cnt,
  output logic                 bit_end
);

  // presc is always at least the minimum ratio, so presc-1 never underflows.
  assign bit_end = en && (edge_cnt == (presc - PRESC_W'(1)));

  // Edge counter wraps at the last oversample of a bit and advances the bit counter; clear has priority.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (clr) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (en) begin
      if (bit_end) begin
        edge_cnt <= '0;
        bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
      end else begin
        edge_cnt <= edge_cnt + PRESC_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive sequencing FSM; UART_RX_ERR_CNT_EN adds saturating parity/stop error counters
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 5,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 RX_IN,
  input  logic [PRESC_W-1:0]   PRESCALE,
  input  logic                 PAR_EN,
  input  logic                 par_err,
  input  logic                 strt_glitch,
  input  logic                 stp_err,
  output logic [PRESC_W-1:0]   edge_cnt,
  output logic [BIT_CNT_W-1:0] bit_cnt,
  output logic                 dat_samp_en,
  output logic                 deser_en,
  output logic                 strt_chk_en,
  output logic                 par_check_en,
  output logic                 stp_chk_en,
  output logic                 data_valid
`ifdef UART_RX_ERR_CNT_EN
  ,
  output logic [7:0]           par_err_cnt,
  output logic [7:0]           stp_err_cnt
`endif
);

  rx_state_e          state;
  logic [PRESC_W-1:0] presc_q;
  logic               par_en_q;
  logic               cnt_en;
  logic               cnt_clr;
  logic               bit_end;
  logic               first_data_cycle;
  logic               glitch_abort;
  logic               last_data_bit;

  // Counters run through START..STOP and sit at zero in IDLE and ERR_CHK.
  assign cnt_en = (state != IDLE) && (state != ERR_CHK);

  // The start checker result lands one cycle after strt_chk_en, i.e. in the first DATA cycle.
  assign first_data_cycle = (state == DATA) && (bit_cnt == BIT_CNT_W'(1)) && (edge_cnt == '0);
  assign glitch_abort     = first_data_cycle && strt_glitch;
  assign last_data_bit    = (bit_cnt == BIT_CNT_W'(DATA_WIDTH));

  // Frames end either at the stop bit end or on a start glitch; both leave the counters at zero.
  assign cnt_clr = (state == IDLE) || (state == ERR_CHK) || glitch_abort ||
                   ((state == STOP) && bit_end);

  uart_rx_edge_bit_cnt #(
    .PRESC_W   (PRESC_W),
    .BIT_CNT_W (BIT_CNT_W)
  ) u_edge_bit_cnt (
    .CLK      (CLK),
    .RST      (RST),
    .en       (cnt_en),
    .clr      (cnt_clr),
    .presc    (presc_q),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt),
    .bit_end  (bit_end)
  );

  // Frame sequencing; PRESCALE and PAR_EN are captured once per frame on leaving IDLE.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      presc_q  <= PRESC_W'(MIN_PRESCALE);
      par_en_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!RX_IN) begin
            state    <= START;
            presc_q  <= PRESC_W'(clamp_prescale(int'(PRESCALE)));
            par_en_q <= PAR_EN;
          end
        end
        START: begin
          if (bit_end) state <= DATA;
        end
        DATA: begin
          if (glitch_abort) begin
            state <= IDLE;
          end else if (bit_end && last_data_bit) begin
            state <= par_en_q ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (bit_end) state <= STOP;
        end
        STOP: begin
          if (bit_end) state <= ERR_CHK;
        end
        ERR_CHK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Per-bit enables fire in the bit-end cycle of their bit; data_valid is gated by the checker flags.
  always_comb begin
    dat_samp_en  = 1'b0;
    strt_chk_en  = 1'b0;
    deser_en     = 1'b0;
    par_check_en = 1'b0;
    stp_chk_en   = 1'b0;
    data_valid   = 1'b0;
    if (state != IDLE) dat_samp_en = 1'b1;
    case (state)
      START:   strt_chk_en  = bit_end;
      DATA:    deser_en     = bit_end;
      PARITY:  par_check_en = bit_end;
      STOP:    stp_chk_en   = bit_end;
      ERR_CHK: data_valid   = !(par_err && par_en_q) && !stp_err;
      default: ;
    endcase
  end

`ifdef UART_RX_ERR_CNT_EN
  // Saturating error tallies, updated once per frame in ERR_CHK and cleared only by reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_err_cnt <= 8'd0;
      stp_err_cnt <= 8'd0;
    end else if (state == ERR_CHK) begin
      if (par_err && par_en_q && (par_err_cnt != 8'hFF)) par_err_cnt <= par_err_cnt + 8'd1;
      if (stp_err && (stp_err_cnt != 8'hFF)) stp_err_cnt <= stp_err_cnt + 8'd1;
    end
  end
`endif

endmodule
